// File: rtl/twiddle_pkg.sv
// Shared types and angle reduction for the twiddle scheduler.
// Holds quadrant encoding, angle constants and the 9-bit angle reducer.
package twiddle_pkg;

    localparam int ANGLE_W     = 9;
    localparam int ANGLE_LIMIT = 360;
    localparam int QUARTER     = 90;
    localparam int ROM_IDX_W   = 7;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    typedef struct packed {
        quadrant_t              quad;
        logic [ROM_IDX_W-1:0]   idx;
        logic                   err;
    } reduced_t;

    function automatic reduced_t reduce_angle(input logic [ANGLE_W-1:0] angle);
        reduced_t r;
        r.quad = Q0;
        r.idx  = '0;
        r.err  = 1'b0;
        if (angle >= ANGLE_W'(ANGLE_LIMIT)) begin
            r.err = 1'b1;
        end else if (angle >= ANGLE_W'(3 * QUARTER)) begin
            r.quad = Q3;
            r.idx  = ROM_IDX_W'(angle - ANGLE_W'(3 * QUARTER));
        end else if (angle >= ANGLE_W'(2 * QUARTER)) begin
            r.quad = Q2;
            r.idx  = ROM_IDX_W'(angle - ANGLE_W'(2 * QUARTER));
        end else if (angle >= ANGLE_W'(QUARTER)) begin
            r.quad = Q1;
            r.idx  = ROM_IDX_W'(angle - ANGLE_W'(QUARTER));
        end else begin
            r.idx  = ROM_IDX_W'(angle);
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starting after the last winner.
// Ports: clk, rst, req (request vector), advance (grant consumed), grant (one-hot).
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] pos;
    logic [IDW-1:0] win;
    logic           found;

    // Scan from last+1 around the ring; first requester found wins.
    always_comb begin
        grant = '0;
        pos   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = IDW'((int'(last) + k) % N_REQ);
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win = IDW'(i);
        end
    end

    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IDW'(N_REQ - 1);
        end else if (advance && |grant) begin
            last <= win;
        end
    end

endmodule

// File: rtl/twiddle_scheduler.sv
// Shares one quarter-wave sin/cos ROM among N_REQ requesters via a 2-stage pipe.
// Ports: clk, rst, req_valid/req_angle/req_ready (requests), rom_angle/rom_sin/
// rom_cos (external ROM), rsp_valid/rsp_ready/rsp_id/rsp_sin/rsp_cos/rsp_err.
module twiddle_scheduler
    import twiddle_pkg::*;
#(
    parameter int W     = 16,
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ANGLE_W-1:0] req_angle,
    output logic [N_REQ-1:0]         req_ready,
    output logic [ROM_IDX_W-1:0]     rom_angle,
    input  logic [W-1:0]             rom_sin,
    input  logic [W-1:0]             rom_cos,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [W:0]               rsp_sin,
    output logic [W:0]               rsp_cos,
    output logic                     rsp_err
);

    logic [N_REQ-1:0]     grant;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 take;

    logic                 s1_valid;
    logic [IDW-1:0]       s1_id;
    quadrant_t            s1_quad;
    logic [ROM_IDX_W-1:0] s1_idx;
    logic                 s1_err;

    logic [IDW-1:0]       sel_id;
    logic [ANGLE_W-1:0]   sel_angle;
    reduced_t             red;

    logic [W:0]           s_ext;
    logic [W:0]           c_ext;
    logic [W:0]           fix_sin;
    logic [W:0]           fix_cos;

    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign take   = |grant && s1_adv;

    // Held low in reset so nothing looks accepted while the pipe is cleared.
    assign req_ready = rst ? '0 : (grant & {N_REQ{s1_adv}});

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (s1_adv),
        .grant   (grant)
    );

    always_comb begin
        sel_id    = '0;
        sel_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_id    = IDW'(i);
                sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    assign red = reduce_angle(sel_angle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_quad  <= Q0;
            s1_idx   <= '0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= take;
            if (take) begin
                s1_id   <= sel_id;
                s1_quad <= red.quad;
                s1_idx  <= red.idx;
                s1_err  <= red.err;
            end
        end
    end

    assign rom_angle = s1_idx;

    assign s_ext = {1'b0, rom_sin};
    assign c_ext = {1'b0, rom_cos};

    always_comb begin
        fix_sin = s_ext;
        fix_cos = c_ext;
        unique case (s1_quad)
            Q0: begin
                fix_sin = s_ext;
                fix_cos = c_ext;
            end
            Q1: begin
                fix_sin = c_ext;
                fix_cos = -s_ext;
            end
            Q2: begin
                fix_sin = -s_ext;
                fix_cos = -c_ext;
            end
            Q3: begin
                fix_sin = -c_ext;
                fix_cos = s_ext;
            end
        endcase
        if (s1_err) begin
            fix_sin = '0;
            fix_cos = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sin   <= '0;
            rsp_cos   <= '0;
            rsp_err   <= 1'b0;
        end else if (s2_adv) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id  <= s1_id;
                rsp_sin <= fix_sin;
                rsp_cos <= fix_cos;
                rsp_err <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_scheduler.sv
// Self-checking bench for twiddle_scheduler with a linear-ramp ROM model.
// Directed scenarios followed by randomized traffic against a scoreboard.
module tb_twiddle_scheduler;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*9-1:0] req_angle;
    logic [N-1:0]   req_ready;
    logic [6:0]     rom_angle;
    logic [W-1:0]   rom_sin;
    logic [W-1:0]   rom_cos;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W:0]     rsp_sin;
    logic [W:0]     rsp_cos;
    logic           rsp_err;

    always #5 clk = ~clk;

    twiddle_scheduler #(.W(W), .N_REQ(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .rom_angle (rom_angle),
        .rom_sin   (rom_sin),
        .rom_cos   (rom_cos),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .rsp_err   (rsp_err)
    );

    // ROM model: sin ramps 0..~FFFF over 0..90, cos is its complement.
    function automatic logic [W-1:0] rom_s(input int x);
        return W'((x * 65535) / 90);
    endfunction

    function automatic logic [W-1:0] rom_c(input int x);
        return W'(65535 - (x * 65535) / 90);
    endfunction

    assign rom_sin = rom_s(int'(rom_angle));
    assign rom_cos = rom_c(int'(rom_angle));

    typedef struct {
        int         id;
        logic [W:0] s;
        logic [W:0] c;
        logic       err;
    } rsp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-circle angle mapped to signed sin/cos from the ROM.
    function automatic rsp_t exp_rsp(input int id, input int a);
        rsp_t r;
        logic [W:0] s;
        logic [W:0] c;
        r.id  = id;
        r.s   = '0;
        r.c   = '0;
        r.err = 1'b0;
        if (a >= 360) begin
            r.err = 1'b1;
            return r;
        end
        s = {1'b0, rom_s(a % 90)};
        c = {1'b0, rom_c(a % 90)};
        case (a / 90)
            0: begin r.s = s;  r.c = c;  end
            1: begin r.s = c;  r.c = -s; end
            2: begin r.s = -s; r.c = -c; end
            default: begin r.s = -c; r.c = s; end
        endcase
        return r;
    endfunction

    rsp_t       exp_q[$];
    rsp_t       log_q[$];
    int         log_cyc[$];
    int         grant_log[$];
    int         model_last = N - 1;
    int         inflight   = 0;
    int         cyc        = 0;
    int         mon_g;
    logic [N-1:0] mon_ready;
    rsp_t       mon_r;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mon_g = -1;
            for (int k = 1; k <= N; k++) begin
                if (mon_g < 0 && req_valid[(model_last + k) % N])
                    mon_g = (model_last + k) % N;
            end
            mon_ready = '0;
            if (mon_g >= 0 && (inflight < 2 || rsp_ready))
                mon_ready[mon_g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(mon_ready));

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    mon_r = exp_q[0];
                    check("rsp_id", 32'(rsp_id), 32'(mon_r.id));
                    check("rsp_sin", 32'(rsp_sin), 32'(mon_r.s));
                    check("rsp_cos", 32'(rsp_cos), 32'(mon_r.c));
                    check("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                end
                if (rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    log_q.push_back('{int'(rsp_id), rsp_sin, rsp_cos, rsp_err});
                    log_cyc.push_back(cyc);
                    inflight--;
                end
            end

            if (|(req_valid & req_ready) && mon_g >= 0) begin
                exp_q.push_back(exp_rsp(mon_g,
                                int'(req_angle[mon_g*9 +: 9])));
                grant_log.push_back(mon_g);
                model_last = mon_g;
                inflight++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int a);
        logic ok;
        ok = 1'b0;
        req_valid[i] = 1'b1;
        req_angle[i*9 +: 9] = 9'(a);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[i];
            tick();
        end
        req_valid[i] = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int t = 0; t < 50 && log_q.size() < n; t++) tick();
        check(tag, 32'(log_q.size()), 32'(n));
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_cyc.delete();
        grant_log.delete();
    endtask

    int           cnt;
    logic [N-1:0] acc;
    logic [N-1:0] last_ready;

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_angle = '0;
        rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sin", 32'(rsp_sin), 32'd0);
        check("rst_rsp_cos", 32'(rsp_cos), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rom_angle", 32'(rom_angle), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Angle 0 on requester 0, two-cycle latency.
        clear_logs();
        req_valid[0] = 1'b1;
        req_angle[8:0] = 9'd0;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_lat_s1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_s2", 32'(rsp_valid), 32'd1);
        check("t1_id", 32'(rsp_id), 32'd0);
        check("t1_sin", 32'(rsp_sin), 32'h00000);
        check("t1_cos", 32'(rsp_cos), 32'h0FFFF);
        check("t1_err", 32'(rsp_err), 32'd0);
        tick();

        // Back-to-back quadrant boundaries on requester 1.
        clear_logs();
        send(1, 90);
        send(1, 180);
        send(1, 270);
        wait_log("t2_count", 3);
        if (log_q.size() == 3) begin
            check("t2_90_sin", 32'(log_q[0].s), 32'h0FFFF);
            check("t2_90_cos", 32'(log_q[0].c), 32'h00000);
            check("t2_180_sin", 32'(log_q[1].s), 32'h00000);
            check("t2_180_cos", 32'(log_q[1].c), 32'h10001);
            check("t2_270_sin", 32'(log_q[2].s), 32'h10001);
            check("t2_270_cos", 32'(log_q[2].c), 32'h00000);
            check("t2_id", 32'(log_q[2].id), 32'd1);
            check("t2_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
            check("t2_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd1);
        end

        // Both requesters continuously valid: alternating grants.
        clear_logs();
        req_valid = '1;
        req_angle = {9'(17), 9'(123)};
        for (int t = 0; t < 40 && grant_log.size() < 6; t++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++)
                if (acc[i]) req_angle[i*9 +: 9] = 9'($urandom_range(0, 359));
        end
        req_valid = '0;
        check("t3_grants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check("t3_order", 32'(grant_log[k]), 32'(k % 2));
        wait_log("t3_count", 6);
        for (int k = 0; k < 6 && k < log_q.size(); k++)
            check("t3_rsp_id", 32'(log_q[k].id), 32'(k % 2));

        // Out-of-range angle, then normal traffic continues.
        clear_logs();
        send(0, 400);
        send(0, 45);
        wait_log("t4_count", 2);
        if (log_q.size() == 2) begin
            check("t4_err", 32'(log_q[0].err), 32'd1);
            check("t4_err_sin", 32'(log_q[0].s), 32'd0);
            check("t4_err_cos", 32'(log_q[0].c), 32'd0);
            check("t4_next_err", 32'(log_q[1].err), 32'd0);
            check("t4_next_sin", 32'(log_q[1].s), 32'(rom_s(45)));
        end

        // Stall for 5 cycles with a continuous stream.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1;
        req_angle[8:0] = 9'($urandom_range(0, 359));
        cnt = 0;
        last_ready = '0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            last_ready = req_ready;
            if (acc[0]) cnt++;
            tick();
            if (acc[0]) req_angle[8:0] = 9'($urandom_range(0, 359));
        end
        check("t5_accepts", 32'(cnt), 32'd2);
        check("t5_ready_low", 32'(last_ready), 32'd0);
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_log("t5_drain", 2);
        tick();
        tick();
        check("t5_no_dup", 32'(log_q.size()), 32'd2);

        // Reset with both stages full.
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1;
        req_angle[8:0] = 9'd10;
        for (int t = 0; t < 4; t++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(rsp_valid), 32'd0);
        check("t6_rom_angle", 32'(rom_angle), 32'd0);
        exp_q.delete();
        inflight   = 0;
        model_last = N - 1;
        clear_logs();
        req_valid = '1;
        req_angle = {9'(200), 9'(300)};
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 10 && grant_log.size() == 0; t++) begin
            @(negedge clk);
            tick();
        end
        req_valid = '0;
        check("t6_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0)
            check("t6_first", 32'(grant_log[0]), 32'd0);
        for (int t = 0; t < 4; t++) tick();

        // Randomized traffic with back-pressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 9) == 0)
                        req_angle[i*9 +: 9] = 9'($urandom_range(360, 511));
                    else
                        req_angle[i*9 +: 9] = 9'($urandom_range(0, 359));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_inflight", 32'(inflight), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
